pa_cpu_clic_int_rcv: RTL and testbench

CPU-side receiver for the CLIC interrupt request interface. Registers the CLIC's winning request (id, level, privilege, hardware-vector flag), qualifies it against the core's interrupt enable and current level, and hands it to the retire unit with a valid/ack handshake. For selective hardware vectoring it fetches the vector-table entry. It drives the CLIC's return path: current id, interrupt-exit strobe and privilege mode.

---
 rtl/pa_clic_pkg.sv | 13 +
 rtl/pa_cpu_clic_vec_rd.sv | 43 ++++
 rtl/pa_cpu_clic_int_rcv.sv | 137 +++++++++++++
 tb/tb_pa_cpu_clic_int_rcv.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_clic_pkg.sv
// pa_clic_pkg: shared types and defaults for the CPU-side CLIC receiver
package pa_clic_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VREQ  = 2'd2,
      VWAIT = 2'd3
   } clic_state_t;
   localparam int CLIC_ID_W = 12;
   localparam int CLIC_IL_W = 8;
   localparam int CLIC_EXIT_HOLD = 2;
   localparam logic [1:0] PRIV_M = 2'b11;
endpackage

// File: rtl/pa_cpu_clic_vec_rd.sv
// pa_cpu_clic_vec_rd: vector-table read for hardware-vectored interrupts (address, bus handshake, PC/err pulses)
module pa_cpu_clic_vec_rd
   import pa_clic_pkg::*;
#(
   parameter int ID_W = CLIC_ID_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  clic_state_t     state,
   input  logic [ID_W-1:0] id,
   input  logic [31:0]     mtvt,
   input  logic            grant,
   input  logic            rd_vld,
   input  logic [31:0]     rd_data,
   input  logic            rd_err,
   output logic            vec_req,
   output logic [31:0]     vec_addr,
   output logic            granted,
   output logic            done,
   output logic            ifu_vec_vld,
   output logic [31:0]     ifu_vec_pc,
   output logic            rtu_vec_err
);
   // request is held for the whole VREQ state; each entry is one 32-bit word
   always_comb begin
      vec_req  = (state == VREQ);
      vec_addr = mtvt + {{(30 - ID_W){1'b0}}, id, 2'b00};
      granted  = vec_req & grant;
      done     = (state == VWAIT) & rd_vld;
   end
   // one-cycle result pulses; the PC drops bit 0 and holds until the next good fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifu_vec_vld <= 1'b0;
         rtu_vec_err <= 1'b0;
         ifu_vec_pc  <= '0;
      end else begin
         ifu_vec_vld <= done & ~rd_err;
         rtu_vec_err <= done & rd_err;
         if (done && !rd_err) ifu_vec_pc <= rd_data & ~32'h1;
      end
   end
endmodule

// File: rtl/pa_cpu_clic_int_rcv.sv
// pa_cpu_clic_int_rcv: CLIC request receiver, retire handshake, optional hardware vector fetch (CLIC_HV_EN), exit strobe
module pa_cpu_clic_int_rcv
   import pa_clic_pkg::*;
#(
   parameter int ID_W      = CLIC_ID_W,
   parameter int IL_W      = CLIC_IL_W,
   parameter int EXIT_HOLD = CLIC_EXIT_HOLD
) (
   input  logic            forever_cpuclk,
   input  logic            cpurst_b,
   input  logic            clic_cpu_int_hv,
   input  logic [ID_W-1:0] clic_cpu_int_id,
   input  logic [IL_W-1:0] clic_cpu_int_il,
   input  logic [1:0]      clic_cpu_int_priv,
   input  logic            cp0_clic_mie,
   input  logic [IL_W-1:0] cp0_clic_mil,
   input  logic [31:0]     cp0_clic_mtvt,
   input  logic [1:0]      cp0_clic_priv_mode,
   output logic            clic_rtu_int_vld,
   output logic [ID_W-1:0] clic_rtu_int_id,
   output logic [IL_W-1:0] clic_rtu_int_il,
   input  logic            rtu_clic_int_ack,
   input  logic            rtu_clic_mret,
   output logic            clic_biu_vec_req,
   output logic [31:0]     clic_biu_vec_addr,
   input  logic            biu_clic_vec_grant,
   input  logic            biu_clic_vec_vld,
   input  logic [31:0]     biu_clic_vec_data,
   input  logic            biu_clic_vec_err,
   output logic            clic_ifu_vec_vld,
   output logic [31:0]     clic_ifu_vec_pc,
   output logic            clic_rtu_vec_err,
   output logic [ID_W-1:0] cpu_clic_curid,
   output logic            cpu_clic_int_exit,
   output logic [1:0]      cpu_clic_mode
);
   localparam int CNT_W = $clog2(EXIT_HOLD + 1);
   clic_state_t     state, state_nxt;
   logic [ID_W-1:0] id_q;
   logic [IL_W-1:0] il_q;
   logic [1:0]      priv_q;
   logic            hv_q, hv_l;
   logic [CNT_W-1:0] exit_cnt;
   logic            elig, take, hv_take, vec_granted, vec_done;
   assign elig = cp0_clic_mie & (il_q != '0) & (priv_q == PRIV_M) & (il_q > cp0_clic_mil);
   assign take = (state == IDLE) & elig & (exit_cnt == '0);
   assign clic_rtu_int_vld = (state == REQ);
   assign cpu_clic_int_exit = (exit_cnt != '0);
   // input stage: CLIC signals cross from the half-rate domain, so flop them every cycle
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         id_q   <= '0;
         il_q   <= '0;
         priv_q <= '0;
         hv_q   <= 1'b0;
      end else begin
         id_q   <= clic_cpu_int_id;
         il_q   <= clic_cpu_int_il;
         priv_q <= clic_cpu_int_priv;
         hv_q   <= clic_cpu_int_hv;
      end
   end
   // state register
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) state <= IDLE;
      else state <= state_nxt;
   end
   // next state: ack beats withdraw; vector states only reachable when hv was latched
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = REQ;
         REQ:     if (rtu_clic_int_ack) state_nxt = hv_take ? VREQ : IDLE;
                  else if (!elig) state_nxt = IDLE;
         VREQ:    if (vec_granted) state_nxt = VWAIT;
         VWAIT:   if (vec_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   // payload latch on take, current id on ack, mode follows the core every cycle
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         clic_rtu_int_id <= '0;
         clic_rtu_int_il <= '0;
         hv_l            <= 1'b0;
         cpu_clic_curid  <= '0;
         cpu_clic_mode   <= PRIV_M;
      end else begin
         if (take) begin
            clic_rtu_int_id <= id_q;
            clic_rtu_int_il <= il_q;
            hv_l            <= hv_q;
         end
         if (state == REQ && rtu_clic_int_ack) cpu_clic_curid <= clic_rtu_int_id;
         cpu_clic_mode <= cp0_clic_priv_mode;
      end
   end
   // exit strobe counter; a new mret reloads it, IDLE waits for it to drain
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) exit_cnt <= '0;
      else if (rtu_clic_mret) exit_cnt <= CNT_W'(EXIT_HOLD);
      else if (exit_cnt != '0) exit_cnt <= exit_cnt - 1'b1;
   end
`ifdef CLIC_HV_EN
   assign hv_take = hv_l;
   pa_cpu_clic_vec_rd #(.ID_W(ID_W)) u_vec_rd (
      .clk         (forever_cpuclk),
      .rst_n       (cpurst_b),
      .state       (state),
      .id          (clic_rtu_int_id),
      .mtvt        (cp0_clic_mtvt),
      .grant       (biu_clic_vec_grant),
      .rd_vld      (biu_clic_vec_vld),
      .rd_data     (biu_clic_vec_data),
      .rd_err      (biu_clic_vec_err),
      .vec_req     (clic_biu_vec_req),
      .vec_addr    (clic_biu_vec_addr),
      .granted     (vec_granted),
      .done        (vec_done),
      .ifu_vec_vld (clic_ifu_vec_vld),
      .ifu_vec_pc  (clic_ifu_vec_pc),
      .rtu_vec_err (clic_rtu_vec_err)
   );
`else
   logic unused_vec;
   assign unused_vec = ^{hv_l, cp0_clic_mtvt, biu_clic_vec_grant, biu_clic_vec_vld,
                         biu_clic_vec_data, biu_clic_vec_err};
   assign hv_take           = 1'b0;
   assign vec_granted       = 1'b0;
   assign vec_done          = 1'b0;
   assign clic_biu_vec_req  = 1'b0;
   assign clic_biu_vec_addr = '0;
   assign clic_ifu_vec_vld  = 1'b0;
   assign clic_ifu_vec_pc   = '0;
   assign clic_rtu_vec_err  = 1'b0;
`endif
endmodule

// File: tb/tb_pa_cpu_clic_int_rcv.sv
// tb_pa_cpu_clic_int_rcv: directed self-checking bench for pa_cpu_clic_int_rcv (vector checks under CLIC_HV_EN)
module tb_pa_cpu_clic_int_rcv;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        hv;
   logic [11:0] id;
   logic [7:0]  il;
   logic [1:0]  priv;
   logic        mie;
   logic [7:0]  mil;
   logic [31:0] mtvt;
   logic [1:0]  pmode;
   logic        vld;
   logic [11:0] rtu_id;
   logic [7:0]  rtu_il;
   logic        ack, mret;
   logic        vreq;
   logic [31:0] vaddr;
   logic        grant, bvld, berr;
   logic [31:0] bdata;
   logic        ivld;
   logic [31:0] ipc;
   logic        verr;
   logic [11:0] curid;
   logic        iexit;
   logic [1:0]  mode;
   int checks = 0;
   int failures = 0;

   pa_cpu_clic_int_rcv dut (
      .forever_cpuclk     (clk),
      .cpurst_b           (rst_n),
      .clic_cpu_int_hv    (hv),
      .clic_cpu_int_id    (id),
      .clic_cpu_int_il    (il),
      .clic_cpu_int_priv  (priv),
      .cp0_clic_mie       (mie),
      .cp0_clic_mil       (mil),
      .cp0_clic_mtvt      (mtvt),
      .cp0_clic_priv_mode (pmode),
      .clic_rtu_int_vld   (vld),
      .clic_rtu_int_id    (rtu_id),
      .clic_rtu_int_il    (rtu_il),
      .rtu_clic_int_ack   (ack),
      .rtu_clic_mret      (mret),
      .clic_biu_vec_req   (vreq),
      .clic_biu_vec_addr  (vaddr),
      .biu_clic_vec_grant (grant),
      .biu_clic_vec_vld   (bvld),
      .biu_clic_vec_data  (bdata),
      .biu_clic_vec_err   (berr),
      .clic_ifu_vec_vld   (ivld),
      .clic_ifu_vec_pc    (ipc),
      .clic_rtu_vec_err   (verr),
      .cpu_clic_curid     (curid),
      .cpu_clic_int_exit  (iexit),
      .cpu_clic_mode      (mode)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; hv = 0; id = 0; il = 0; priv = 0; mie = 0; mil = 0; mtvt = 0;
      pmode = 2'b00; ack = 0; mret = 0; grant = 0; bvld = 0; berr = 0; bdata = 0;
      repeat (2) tick;
      chk("rst_mode", 32'(mode), 32'd3);
      chk("rst_vld", 32'(vld), 0);
      chk("rst_curid", 32'(curid), 0);
      chk("rst_exit", 32'(iexit), 0);
      chk("rst_vreq", 32'(vreq), 0);
      rst_n = 1'b1;
      tick;
      chk("mode_follow", 32'(mode), 0);
      // basic take
      pmode = 2'b11; mie = 1; mil = 0; id = 12'd20; il = 8'h40; priv = 2'b11; hv = 0;
      tick;
      chk("take_lat1", 32'(vld), 0);
      tick;
      chk("take_vld", 32'(vld), 1);
      chk("take_id", 32'(rtu_id), 20);
      chk("take_il", 32'(rtu_il), 32'h40);
      tick; tick;
      chk("take_hold", 32'(vld), 1);
      ack = 1; il = 0;
      tick;
      ack = 0;
      chk("take_curid", 32'(curid), 20);
      chk("take_drop", 32'(vld), 0);
      chk("take_novreq", 32'(vreq), 0);
      // wrong privilege never qualifies
      priv = 2'b01; il = 8'h40;
      tick; tick; tick;
      chk("priv_mask", 32'(vld), 0);
      priv = 2'b11; il = 0;
      tick;
      // level mask, then a level above mil
      mil = 8'h80; il = 8'h40; id = 12'd5;
      repeat (4) begin tick; chk("lvl_mask", 32'(vld), 0); end
      il = 8'h81;
      tick; tick;
      chk("unmask_vld", 32'(vld), 1);
      chk("unmask_il", 32'(rtu_il), 32'h81);
      chk("unmask_id", 32'(rtu_id), 5);
      // withdraw before ack
      il = 0;
      tick;
      chk("wd_lag", 32'(vld), 1);
      tick;
      chk("wd_vld", 32'(vld), 0);
      chk("wd_curid", 32'(curid), 20);
      // ack and withdraw seen together: ack wins
      id = 12'd7; il = 8'h81;
      tick; tick;
      chk("ackwd_vld", 32'(vld), 1);
      il = 0;
      tick;
      ack = 1;
      tick;
      ack = 0;
      chk("ackwd_curid", 32'(curid), 7);
      chk("ackwd_vld0", 32'(vld), 0);
      mil = 0;
      // hardware-vectored request
      hv = 1; id = 12'd3; il = 8'h40; mtvt = 32'h2000_0000;
      tick; tick;
      chk("hv_vld", 32'(vld), 1);
      ack = 1; il = 0; hv = 0;
      tick;
      ack = 0;
      chk("hv_curid", 32'(curid), 3);
`ifdef CLIC_HV_EN
      chk("hv_vreq", 32'(vreq), 1);
      chk("hv_addr", vaddr, 32'h2000_000C);
      tick; tick;
      chk("hv_vreq_hold", 32'(vreq), 1);
      grant = 1;
      tick;
      grant = 0;
      chk("hv_vreq_off", 32'(vreq), 0);
      tick;
      chk("hv_wait_novld", 32'(ivld), 0);
      bvld = 1; bdata = 32'h0000_1235;
      tick;
      bvld = 0;
      chk("hv_ivld", 32'(ivld), 1);
      chk("hv_pc", ipc, 32'h0000_1234);
      chk("hv_noerr", 32'(verr), 0);
      tick;
      chk("hv_ivld_pulse", 32'(ivld), 0);
      chk("hv_idle", 32'(vld), 0);
      // vector fetch bus error
      hv = 1; id = 12'd3; il = 8'h40;
      tick; tick;
      ack = 1; il = 0; hv = 0;
      tick;
      ack = 0; grant = 1;
      tick;
      grant = 0; bvld = 1; berr = 1; bdata = 32'hFFFF_FFFF;
      tick;
      bvld = 0; berr = 0;
      chk("err_pulse", 32'(verr), 1);
      chk("err_noivld", 32'(ivld), 0);
      tick;
      chk("err_pulse_end", 32'(verr), 0);
`else
      chk("nohv_vreq", 32'(vreq), 0);
      chk("nohv_addr", vaddr, 0);
      tick;
      chk("nohv_ivld", 32'(ivld), 0);
      chk("nohv_idle", 32'(vld), 0);
`endif
      // exit strobe with a pending eligible request
      mret = 1; id = 12'd9; il = 8'h40;
      tick;
      mret = 0;
      chk("exit_c1", 32'(iexit), 1);
      chk("exit_c1_vld", 32'(vld), 0);
      tick;
      chk("exit_c2", 32'(iexit), 1);
      chk("exit_c2_vld", 32'(vld), 0);
      tick;
      chk("exit_c3", 32'(iexit), 0);
      chk("exit_c3_vld", 32'(vld), 0);
      tick;
      chk("exit_c4_vld", 32'(vld), 1);
      chk("exit_curid_held", 32'(curid), 3);
      ack = 1; il = 0;
      tick;
      ack = 0;
      chk("exit_curid", 32'(curid), 9);
      // mret while counting reloads
      mret = 1;
      tick;
      mret = 0;
      chk("rl_a", 32'(iexit), 1);
      tick;
      chk("rl_b", 32'(iexit), 1);
      mret = 1;
      tick;
      mret = 0;
      chk("rl_c", 32'(iexit), 1);
      tick;
      chk("rl_d", 32'(iexit), 1);
      tick;
      chk("rl_e", 32'(iexit), 0);
      // reset mid-operation (in VWAIT when vectoring is built)
      pmode = 2'b01; hv = 1; id = 12'd11; il = 8'h40;
      tick; tick;
      chk("rs_vld", 32'(vld), 1);
      chk("rs_mode", 32'(mode), 1);
`ifdef CLIC_HV_EN
      ack = 1; il = 0; hv = 0;
      tick;
      ack = 0; grant = 1;
      tick;
      grant = 0;
`endif
      il = 0; hv = 0;
      #1 rst_n = 1'b0;
      #1;
      chk("rs_vld0", 32'(vld), 0);
      chk("rs_curid0", 32'(curid), 0);
      chk("rs_mode3", 32'(mode), 3);
      chk("rs_vreq0", 32'(vreq), 0);
      chk("rs_id0", 32'(rtu_id), 0);
      rst_n = 1'b1;
      bvld = 1; bdata = 32'h0000_5678;
      tick;
      bvld = 0;
      chk("rs_late_ivld", 32'(ivld), 0);
      chk("rs_late_err", 32'(verr), 0);
      chk("rs_late_vld", 32'(vld), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
